// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, status register and
// programmable baud divisor; responds to CPU loads/stores qualified by sel.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          r_state;
  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_cnt;
  logic [15:0]     r_div_lat;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic [15:0]     r_baud;
  logic            r_ovf;

  state_e          w_state_nxt;
  logic [15:0]     w_cnt_nxt;
  logic [15:0]     w_div_nxt;
  logic [2:0]      w_idx_nxt;
  logic [2:0]      w_idx_inc;
  logic [7:0]      w_shift_nxt;
  logic            w_tx_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_full;
  logic            w_empty;
  logic            w_busy;
  logic            w_bit_end;
  logic [15:0]     w_div_eff;
  logic            w_wr_txdata;
  logic            w_wr_status;
  logic            w_wr_baud;
  logic            w_push;
  logic            w_push_rej;
  logic            w_pop;
  logic            w_unused_ok;

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  assign w_busy      = (r_state != StIdle);
  assign w_div_eff   = (r_baud == 16'd0) ? 16'd1 : r_baud;
  assign w_bit_end   = (r_cnt == r_div_lat - 16'd1);
  assign w_idx_inc   = r_bit_idx + 3'd1;
  assign w_wr_txdata = sel && mem_write && (addr[3:2] == 2'd0);
  assign w_wr_status = sel && mem_write && (addr[3:2] == 2'd1);
  assign w_wr_baud   = sel && mem_write && (addr[3:2] == 2'd2);
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign w_push      = w_wr_txdata && !w_full;
  assign w_push_rej  = w_wr_txdata && w_full;
  assign w_unused_ok = ^{wdata[31:16], addr[1:0]};

  assign tx        = r_tx;
  assign irq_empty = w_empty && !w_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div_lat;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_tx_nxt = 1'b1;
        w_pop    = !w_empty;
      end
      StStart: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = StData;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = StStop;
            w_tx_nxt    = 1'b1;
          end else begin
            w_idx_nxt = w_idx_inc;
            w_tx_nxt  = r_shift[w_idx_inc];
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
          w_tx_nxt    = 1'b1;
          w_pop       = !w_empty;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    // Frame start: the divisor is captured here so later BAUDDIV writes wait a frame.
    if (w_pop) begin
      w_shift_nxt = r_fifo[r_rd_ptr];
      w_div_nxt   = w_div_eff;
      w_cnt_nxt   = '0;
      w_state_nxt = StStart;
      w_tx_nxt    = 1'b0;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (sel && mem_read) begin
      case (addr[3:2])
        2'd1:    rdata = {28'h0, r_ovf, w_busy, w_empty, w_full};
        2'd2:    rdata = {16'h0, r_baud};
        default: rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_div_lat <= 16'd1;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_baud    <= DEFAULT_DIV;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div_lat <= w_div_nxt;
      r_bit_idx <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_baud) r_baud <= wdata[15:0];
      if (w_push_rej) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status && wdata[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= wdata[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a frame-level reference model is
// compared every cycle, plus directed literal checks of key timing points.
module tb_mmio_uart_tx;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] DEF_DIV = 16'd10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  addr = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq_empty;

  int n_checks = 0;
  int n_err = 0;
  bit m_on = 1'b0;

  mmio_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(DEF_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .addr     (addr),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx       (tx),
    .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus a queue of per-cycle line levels for the
  // frame in flight (element 0 is the level driven in the current cycle).
  logic [7:0]  mq[$];
  bit          mw[$];
  logic [15:0] mb = DEF_DIV;
  bit          mo = 1'b0;

  always @(posedge clk) begin
    int          sz;
    bit          start, push, rej;
    logic [7:0]  b;
    int unsigned d;
    bit          lvl;
    if (!reset) begin
      mq.delete();
      mw.delete();
      mb = DEF_DIV;
      mo = 1'b0;
    end else begin
      sz = mq.size();
      if (mw.size() > 0) void'(mw.pop_front());
      start = (mw.size() == 0) && (sz > 0);
      push  = sel && mem_write && (addr[3:2] == 2'd0);
      rej   = push && (sz >= DEPTH);
      if (start) begin
        b = mq.pop_front();
        d = (mb == 16'd0) ? 1 : int'(mb);
        for (int i = 0; i < 10; i++) begin
          lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
          for (int j = 0; j < int'(d); j++) mw.push_back(lvl);
        end
      end
      if (push && !rej) mq.push_back(wdata[7:0]);
      if (sel && mem_write && addr[3:2] == 2'd1 && wdata[3]) mo = 1'b0;
      if (rej) mo = 1'b1;
      if (sel && mem_write && addr[3:2] == 2'd2) mb = wdata[15:0];
    end
  end

  function automatic logic [31:0] model_rdata();
    logic [31:0] r;
    r = 32'h0;
    if (sel && mem_read) begin
      case (addr[3:2])
        2'd1: r = {28'h0, mo, (mw.size() > 0), (mq.size() == 0), (mq.size() == DEPTH)};
        2'd2: r = {16'h0, mb};
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_tx", {31'h0, tx}, {31'h0, (mw.size() > 0) ? mw[0] : 1'b1});
      chk("model_irq", {31'h0, irq_empty}, {31'h0, (mq.size() == 0) && (mw.size() == 0)});
      chk("model_rdata", rdata, model_rdata());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    sel = 1'b0; mem_write = 1'b0; mem_read = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; addr = a; mem_write = 1'b1; mem_read = 1'b0; wdata = d;
    tick();
    idle_bus();
  endtask

  task automatic rd_chk(input string name, input logic s, input logic [3:0] a,
                        input logic [31:0] exp);
    sel = s; addr = a; mem_read = 1'b1; mem_write = 1'b0;
    #1;
    chk(name, rdata, exp);
    idle_bus();
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (irq_empty !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk(name, {31'h0, irq_empty}, 32'h1);
  endtask

  initial begin
    logic [9:0]  pat;
    logic [31:0] r;
    int unsigned op;

    idle_bus();
    reset = 1'b0;
    tick();
    m_on = 1'b1;
    tick();
    reset = 1'b1;

    chk("reset_tx", {31'h0, tx}, 32'h1);
    chk("reset_irq", {31'h0, irq_empty}, 32'h1);
    rd_chk("reset_status", 1'b1, 4'h4, 32'h2);
    rd_chk("reset_baud", 1'b1, 4'h8, 32'd10);

    // 0xA5 at divisor 4: exact 40-cycle waveform.
    wr(4'h8, 32'd4);
    wr(4'h0, 32'hA5);
    chk("a5_pre_tx", {31'h0, tx}, 32'h1);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("a5_wave", {31'h0, tx}, {31'h0, pat[c/4]});
      if (c == 0) chk("a5_irq_busy", {31'h0, irq_empty}, 32'h0);
    end
    tick();
    chk("a5_irq_done", {31'h0, irq_empty}, 32'h1);

    // Five pushes at divisor 2: first pops at once, none dropped.
    wr(4'h8, 32'd2);
    for (int i = 1; i <= 5; i++) wr(4'h0, i);
    rd_chk("five_status", 1'b1, 4'h4, 32'h5);
    wait_idle("five_drain", 200);

    // Six pushes: sixth dropped, overflow set, then cleared.
    for (int i = 0; i < 6; i++) wr(4'h0, 32'h10 + i);
    rd_chk("six_status", 1'b1, 4'h4, 32'hD);
    wr(4'h4, 32'h8);
    rd_chk("ovf_clear", 1'b1, 4'h4, 32'h5);
    wait_idle("six_drain", 200);

    // Divisor 0 behaves as 1: 10-cycle frame.
    wr(4'h8, 32'd0);
    wr(4'h0, 32'h3C);
    repeat (10) tick();
    chk("div0_busy", {31'h0, irq_empty}, 32'h0);
    tick();
    chk("div0_done", {31'h0, irq_empty}, 32'h1);

    // Divisor change mid-frame and back-to-back frames.
    wr(4'h8, 32'd4);
    wr(4'h0, 32'h55);
    wr(4'h0, 32'hF0);
    wr(4'h8, 32'd8);
    repeat (38) tick();
    chk("b2b_stop", {31'h0, tx}, 32'h1);
    tick();
    chk("b2b_start", {31'h0, tx}, 32'h0);
    chk("b2b_irq", {31'h0, irq_empty}, 32'h0);
    repeat (79) tick();
    chk("slow_busy", {31'h0, irq_empty}, 32'h0);
    tick();
    chk("slow_done", {31'h0, irq_empty}, 32'h1);

    // Reset during DATA discards the frame and queued bytes.
    wr(4'h8, 32'd4);
    wr(4'h0, 32'h00);
    wr(4'h0, 32'h77);
    repeat (9) tick();
    chk("mid_data_tx", {31'h0, tx}, 32'h0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_tx", {31'h0, tx}, 32'h1);
    rd_chk("abort_status", 1'b1, 4'h4, 32'h2);
    rd_chk("abort_baud", 1'b1, 4'h8, 32'd10);

    rd_chk("reserved_rd", 1'b1, 4'hC, 32'h0);
    rd_chk("txdata_rd", 1'b1, 4'h0, 32'h0);
    rd_chk("nosel_rd", 1'b0, 4'h8, 32'h0);

    // Randomised traffic; the per-cycle model comparison does the checking.
    wr(4'h8, 32'd1);
    for (int i = 0; i < 4000; i++) begin
      r  = $urandom();
      op = $urandom_range(0, 99);
      idle_bus();
      reset = (op == 99) ? 1'b0 : 1'b1;
      sel = ($urandom_range(0, 7) != 0);
      addr = 4'($urandom_range(0, 15));
      if (op < 40) begin
        addr[3:2] = 2'd0; mem_write = 1'b1; wdata = r;
      end else if (op < 46) begin
        addr[3:2] = 2'd2; mem_write = 1'b1; wdata = {r[31:16], 14'h0, r[1:0]};
      end else if (op < 52) begin
        addr[3:2] = 2'd1; mem_write = 1'b1; wdata = r;
      end else if (op < 55) begin
        addr[3:2] = 2'd3; mem_write = 1'b1; wdata = r;
      end
      mem_read = ($urandom_range(0, 1) == 1);
      tick();
    end
    idle_bus();
    reset = 1'b1;
    wait_idle("final_drain", 2000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter; a responder on the CPU data-memory port.
- Accepts CPU store/load accesses decoded by an external address decoder via `sel`.
- Buffers bytes in a FIFO and serialises them as 8N1 frames, LSB first, on `tx`.
- Gives SingleCycleCPU programs observable output without changing the core.

Parameters:
- FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2.
- DEFAULT_DIV, 16'd10, reset value of BAUDDIV in clock cycles per bit.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- sel  in  1  address decoder hit for this peripheral.
- addr  in  4  byte offset; only addr[3:2] is decoded.
- mem_write  in  1  store strobe, qualified by sel.
- mem_read  in  1  load strobe, qualified by sel.
- wdata  in  32  store data.
- rdata  out  32  load data, combinational.
- tx  out  1  serial line, idle high.
- irq_empty  out  1  high when the FIFO is empty and the serialiser is idle.

Behaviour:
- Reset (reset==0 at an edge):
  - FIFO count, read pointer and write pointer = 0.
  - FSM = IDLE; tx = 1.
  - BAUDDIV = DEFAULT_DIV; overflow = 0.
  - irq_empty = 1 after the edge.
  - Reset mid-frame aborts the frame: tx returns to 1 at that edge and queued bytes are discarded.
- Register map, by addr[3:2]:
  - 0 TXDATA: write pushes wdata[7:0]; reads return 0.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 overflow; all other bits 0.
  - 1 STATUS (write): writing 1 to wdata[3] clears overflow; all other bits are ignored.
  - 2 BAUDDIV: read/write on bits [15:0]; bits [31:16] read as 0.
  - 3: reserved; reads return 0 and writes are ignored.
- rdata:
  - Combinational; equals the selected register when sel & mem_read, else 32'h0.
  - Reflects state registered at the previous edge.
- Push (sel & mem_write & addr[3:2]==0):
  - If count < FIFO_DEPTH, the byte is written at the edge.
  - If full, the byte is dropped and overflow is set to 1.
  - Full is judged on the current count: a push is rejected even if a pop occurs in the same cycle.
  - A simultaneous accepted push and pop leaves count unchanged.
- Overflow set and clear in the same cycle: set wins.
- Effective divisor: div_eff = max(BAUDDIV, 1).
  - Latched at frame start.
  - A BAUDDIV write mid-frame affects only later frames.
- FSM states: IDLE, START, DATA, STOP. A cycle counter runs to div_eff and a bit index runs 0..7.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START at that edge. tx = 1.
  - START: tx = 0 for div_eff cycles, then DATA with index 0.
  - DATA: tx = shift[index] for div_eff cycles per bit; after bit 7, go to STOP.
  - STOP: tx = 1 for div_eff cycles.
    - If the FIFO is non-empty at the end, pop and go directly to START (back-to-back, no idle gap).
    - Otherwise go to IDLE.
- Frame length: exactly 10*div_eff cycles.
- tx is registered (glitch-free).
- Latency:
  - Push accepted at edge k into an empty FIFO with the FSM idle: pop at edge k+1.
  - tx = 0 from edge k+1 for div_eff cycles.
- irq_empty = (count==0) & (state==IDLE), registered-state derived.

Test Plan:
- Reset, then write BAUDDIV=4 and TXDATA=0xA5 -> tx low 4 cycles starting one edge after the push edge, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; total 40 cycles; irq_empty returns to 1.
- Push 0x01,0x02,0x03,0x04,0x05 back-to-back (FIFO_DEPTH=4, divisor 2) -> first byte pops immediately, so all five are accepted and overflow stays 0.
- Push 6 bytes back-to-back -> the sixth is dropped and STATUS reads 0xD (full, busy, overflow).
- Write STATUS=0x8 -> overflow clears; the next STATUS read has bit3 = 0.
- BAUDDIV=0 -> frame is 10 cycles (divisor treated as 1).
- BAUDDIV changed from 4 to 8 mid-frame -> the current frame stays 40 cycles and the next frame is 80 cycles.
- Two queued bytes -> the stop bit of the first is followed immediately by the start bit of the second; no idle cycle between frames.
- reset=0 asserted mid-DATA -> tx = 1 and STATUS = 0x2 after that edge.
- Read of addr 0xC -> rdata = 0.
- mem_read with sel=0 -> rdata = 0.
